// File: rtl/frame_mean_calc.sv
// frame_mean_calc
// Computes the mean luminance of the frame held in BRAM. The block walks the
// read port across every pixel and converts each RGB triple to an 8-bit gray
// value. It accumulates the gray values, then divides the sum by the pixel
// count with a bit-serial restoring divider. The mean feeds img_processing.

module frame_mean_calc #(
   parameter int NUM_PIXELS = 76800,
   parameter int ADDR_W     = 17,
   parameter int ACC_W      = 25
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] addr_read,
   input  logic [7:0]        red_data_in,
   input  logic [7:0]        green_data_in,
   input  logic [7:0]        blue_data_in,
   output logic [7:0]        mean
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_DIV   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam int                CNT_W     = $clog2(ACC_W) + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
   localparam logic [ACC_W:0]    DIVISOR   = (ACC_W + 1)'(NUM_PIXELS);
   localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(ACC_W - 1);

   logic [2:0]       state;
   logic             rd_valid;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] rem;
   logic [CNT_W-1:0] div_cnt;

   logic [9:0]       gray_sum;
   logic [7:0]       gray;
   logic [ACC_W:0]   rem_shift;
   logic [ACC_W:0]   rem_next;
   logic             q_bit;
   logic [ACC_W-1:0] quot_next;

   // Gray value of the sample on the read bus: (R + 2G + B) / 4 at 10 bits
   always_comb begin
      gray_sum = {2'b00, red_data_in} + {1'b0, green_data_in, 1'b0} + {2'b00, blue_data_in};
      gray     = 8'(gray_sum >> 2);
   end

   // One restoring-division step; acc doubles as dividend (shifting out) and quotient (shifting in)
   always_comb begin
      rem_shift = {rem, acc[ACC_W-1]};
      q_bit     = (rem_shift >= DIVISOR);
      rem_next  = q_bit ? (rem_shift - DIVISOR) : rem_shift;
      quot_next = {acc[ACC_W-2:0], q_bit};
   end

   assign busy = (state == S_READ) || (state == S_DRAIN) || (state == S_DIV);
   assign done = (state == S_DONE);

   // Sequencer: address sweep, drain slot, divide step counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         addr_read <= '0;
         div_cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               addr_read <= '0;
               if (start) begin
                  state <= S_READ;
               end
            end
            S_READ: begin
               if (addr_read == LAST_ADDR) begin
                  state <= S_DRAIN;
               end else begin
                  addr_read <= addr_read + ADDR_W'(1);
               end
            end
            S_DRAIN: begin
               state   <= S_DIV;
               div_cnt <= '0;
            end
            S_DIV: begin
               if (div_cnt == LAST_STEP) begin
                  state <= S_DONE;
               end else begin
                  div_cnt <= div_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               addr_read <= '0;
            end
            default: begin
               state     <= S_IDLE;
               addr_read <= '0;
            end
         endcase
      end
   end

   // Read-valid pipe, accumulator and divider; the remainder stays below the divisor after each step, so its top bit is always zero
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         acc      <= '0;
         rem      <= '0;
      end else begin
         rd_valid <= (state == S_READ);
         if (state == S_IDLE && start) begin
            acc <= '0;
         end else if (state == S_DIV) begin
            acc <= quot_next;
         end else if (rd_valid) begin
            acc <= acc + ACC_W'(gray);
         end
         if (state == S_DIV) begin
            rem <= ACC_W'(rem_next);
         end else begin
            rem <= '0;
         end
      end
   end

   // Mean is captured on the last divide step so that it is valid in the done cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         mean <= '0;
      end else if (state == S_DIV && div_cnt == LAST_STEP) begin
         mean <= quot_next[7:0];
      end
   end

endmodule

// File: tb/tb_frame_mean_calc.sv
// tb_frame_mean_calc
// Drives frame_mean_calc with a small 4-pixel frame from a BRAM model and
// compares against a plain-arithmetic mean computed from the frame contents.

module tb_frame_mean_calc;

   localparam int NUM_PIXELS = 4;
   localparam int ADDR_W     = 3;
   localparam int ACC_W      = 10;
   localparam int DONE_CYCLE = NUM_PIXELS + ACC_W + 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] addr_read;
   logic [7:0]        red_data;
   logic [7:0]        green_data;
   logic [7:0]        blue_data;
   logic [7:0]        mean;

   logic [7:0] mem_r [0:7];
   logic [7:0] mem_g [0:7];
   logic [7:0] mem_b [0:7];

   int tests_run    = 0;
   int tests_failed = 0;
   int prev_mean    = 0;

   frame_mean_calc #(
      .NUM_PIXELS(NUM_PIXELS),
      .ADDR_W    (ADDR_W),
      .ACC_W     (ACC_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .addr_read    (addr_read),
      .red_data_in  (red_data),
      .green_data_in(green_data),
      .blue_data_in (blue_data),
      .mean         (mean)
   );

   always #5 clk = ~clk;

   // BRAM model with one cycle of read latency
   always @(posedge clk) begin
      red_data   <= mem_r[addr_read];
      green_data <= mem_g[addr_read];
      blue_data  <= mem_b[addr_read];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic loadConst(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      for (int i = 0; i < 8; i++) begin
         mem_r[i] = r;
         mem_g[i] = g;
         mem_b[i] = b;
      end
   endtask

   task automatic loadRandom();
      for (int i = 0; i < 8; i++) begin
         mem_r[i] = 8'($urandom);
         mem_g[i] = 8'($urandom);
         mem_b[i] = 8'($urandom);
      end
   endtask

   function automatic int refMean();
      int sum = 0;
      for (int i = 0; i < NUM_PIXELS; i++) begin
         sum += (int'(mem_r[i]) + 2 * int'(mem_g[i]) + int'(mem_b[i])) / 4;
      end
      return sum / NUM_PIXELS;
   endfunction

   // Start a pass and check every cycle from cycle 1 through a few idle cycles after done
   task automatic applyStimulus(input int exp_mean, input bit extra_starts);
      int done_seen = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= DONE_CYCLE + 3; c++) begin
         if (c <= NUM_PIXELS)
            checkOutput("addr_sweep", addr_read, c - 1);
         else if (c <= DONE_CYCLE)
            checkOutput("addr_hold", addr_read, NUM_PIXELS - 1);
         else
            checkOutput("addr_idle", addr_read, 0);
         checkOutput("busy", busy, (c < DONE_CYCLE) ? 1 : 0);
         checkOutput("done", done, (c == DONE_CYCLE) ? 1 : 0);
         checkOutput("mean", mean, (c < DONE_CYCLE) ? prev_mean : exp_mean);
         if (done === 1'b1) done_seen++;
         start = extra_starts && (c == 3 || c == DONE_CYCLE);
         tick();
      end
      start = 1'b0;
      checkOutput("done_count", done_seen, 1);
      prev_mean = exp_mean;
   endtask

   initial begin
      // Reset held three cycles with a start request that must be ignored
      rst   = 1'b1;
      start = 1'b1;
      loadConst(8'd255, 8'd255, 8'd255);
      tick();
      tick();
      tick();
      rst   = 1'b0;
      start = 1'b0;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_mean", mean, 0);
      checkOutput("rst_addr", addr_read, 0);
      tick();
      tick();
      checkOutput("rst_no_activity", busy, 0);

      // Full-white frame with stray start requests during the pass and in the done cycle
      applyStimulus(255, 1'b1);

      // Mixed frame: grays 50, 0, 40, 4 give a floored mean of 23
      mem_r[0] = 8'd100; mem_g[0] = 8'd50; mem_b[0] = 8'd0;
      mem_r[1] = 8'd0;   mem_g[1] = 8'd0;  mem_b[1] = 8'd0;
      mem_r[2] = 8'd40;  mem_g[2] = 8'd40; mem_b[2] = 8'd40;
      mem_r[3] = 8'd4;   mem_g[3] = 8'd4;  mem_b[3] = 8'd4;
      checkOutput("ref_model_23", refMean(), 23);
      applyStimulus(refMean(), 1'b0);

      // Abort a pass with reset in cycle 8
      loadConst(8'd77, 8'd33, 8'd11);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 8; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_addr", addr_read, 0);
      checkOutput("abort_mean", mean, 0);
      begin
         int stray_done = 0;
         for (int c = 0; c < DONE_CYCLE + 4; c++) begin
            if (done !== 1'b0) stray_done++;
            tick();
         end
         checkOutput("abort_no_done", stray_done, 0);
      end
      prev_mean = 0;
      applyStimulus(refMean(), 1'b0);

      // Back-to-back passes: mean must hold 10 through the second pass
      loadConst(8'd10, 8'd10, 8'd10);
      applyStimulus(10, 1'b0);
      loadConst(8'd200, 8'd200, 8'd200);
      applyStimulus(200, 1'b0);

      // Random frames against the arithmetic reference
      for (int k = 0; k < 5; k++) begin
         loadRandom();
         applyStimulus(refMean(), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
